// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 definitions: prefix FSM states, code constants,
// the ignore list and the resolved-code record passed between blocks.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;

  // Keyboard status/response bytes that carry no key information
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_FL = 8'hFC;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  typedef struct packed {
    logic       strobe;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_code_t;

  function automatic logic ps2_is_ignored(input logic [7:0] b);
    return (b == PS2_ERR0)   || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
           (b == PS2_ACK)    || (b == PS2_BAT_FL) || (b == PS2_RESEND) ||
           (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// E0/F0 prefix stripper with idle timeout. Emits one resolved
// {strobe, ext, brk, code} in the same cycle as the final byte, so the
// consumer's registers see the key at the edge ending that cycle.
module ps2_prefix_fsm
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output ps2_code_t  o_code
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  prefix_state_t    state, next_state;
  logic [CNT_W-1:0] cnt;

  // Next prefix state and resolved code; a byte takes priority over timeout
  always_comb begin
    next_state  = state;
    o_code      = '0;
    o_code.code = i_byte;
    if (i_byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (i_byte == PS2_EXT)       next_state = ST_EXT;
          else if (i_byte == PS2_BRK)  next_state = ST_BRK;
          else if (!ps2_is_ignored(i_byte)) o_code.strobe = 1'b1;
        end
        ST_EXT: begin
          if (i_byte == PS2_BRK) next_state = ST_EXT_BRK;
          else begin
            o_code.strobe = 1'b1;
            o_code.ext    = 1'b1;
            next_state    = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (i_byte == PS2_EXT) next_state = ST_EXT;
          else begin
            o_code.strobe = 1'b1;
            o_code.brk    = 1'b1;
            next_state    = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (i_byte == PS2_EXT) next_state = ST_EXT;
          else begin
            o_code.strobe = 1'b1;
            o_code.ext    = 1'b1;
            o_code.brk    = 1'b1;
            next_state    = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end else if ((state != ST_IDLE) && (cnt == CNT_LAST)) begin
      next_state = ST_IDLE;
    end
  end

  // State register and timeout counter (held at zero whenever heading to IDLE)
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (i_byte_valid || (next_state == ST_IDLE)) cnt <= '0;
      else                                         cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_keystate.sv
// PS/2 key tracker: shift/capslock state and the last held non-modifier key.
// Optional macro PS2_KEYSTATE_REPEAT_FILTER_EN suppresses o_make on
// typematic repeats of the key already shown on o_scancode.
module ps2_keystate
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic [7:0] o_scancode,
  output logic       o_valid,
  output logic       o_make,
  output logic       o_shift,
  output logic       o_capslock
);

  ps2_code_t res;
  logic      lshift_held, rshift_held, caps_held;
  logic      repeat_hit;

  ps2_prefix_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_prefix (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_byte      (i_byte),
    .i_byte_valid(i_byte_valid),
    .o_code      (res)
  );

`ifdef PS2_KEYSTATE_REPEAT_FILTER_EN
  assign repeat_hit = o_valid && (o_scancode == res.code);
`else
  assign repeat_hit = 1'b0;
`endif

  // Apply resolved non-extended codes to modifier and key-held state
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_scancode  <= '0;
      o_valid     <= 1'b0;
      o_make      <= 1'b0;
      o_shift     <= 1'b0;
      o_capslock  <= 1'b0;
      lshift_held <= 1'b0;
      rshift_held <= 1'b0;
      caps_held   <= 1'b0;
    end else begin
      o_make <= 1'b0;
      if (res.strobe && !res.ext) begin
        case (res.code)
          PS2_LSHIFT: begin
            lshift_held <= !res.brk;
            o_shift     <= !res.brk || rshift_held;
          end
          PS2_RSHIFT: begin
            rshift_held <= !res.brk;
            o_shift     <= lshift_held || !res.brk;
          end
          PS2_CAPS: begin
            if (res.brk) caps_held <= 1'b0;
            else if (!caps_held) begin
              caps_held  <= 1'b1;
              o_capslock <= !o_capslock;
            end
          end
          default: begin
            if (res.brk) begin
              if (res.code == o_scancode) o_valid <= 1'b0;
            end else begin
              o_scancode <= res.code;
              o_valid    <= 1'b1;
              o_make     <= !repeat_hit;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keystate.sv
// Directed bench for ps2_keystate with an expectation queue: each driven
// cycle pushes the expected output set, which is popped and compared after
// the clock edge that should produce it.
module tb_ps2_keystate;

  localparam int unsigned T_CYC = 16;
  localparam int unsigned C_W   = 5;

`ifdef PS2_KEYSTATE_REPEAT_FILTER_EN
  localparam logic REP_MAKE = 1'b0;
`else
  localparam logic REP_MAKE = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic [7:0] o_scancode;
  logic       o_valid, o_make, o_shift, o_capslock;

  ps2_keystate #(
    .TIMEOUT_CYCLES(T_CYC),
    .CNT_W         (C_W)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_byte      (i_byte),
    .i_byte_valid(i_byte_valid),
    .o_scancode  (o_scancode),
    .o_valid     (o_valid),
    .o_make      (o_make),
    .o_shift     (o_shift),
    .o_capslock  (o_capslock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sc;
    logic       v, m, s, c;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         step_no = 0;

  // Bench-side view of what the outputs should be
  logic [7:0] e_sc = 8'h00;
  logic       e_v = 1'b0, e_s = 1'b0, e_c = 1'b0;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL queue_empty step %0d observed=0 expected=1", step_no);
    end else begin
      e = q.pop_front();
      cmp("scancode", o_scancode, e.sc);
      cmp("valid",    {7'd0, o_valid},    {7'd0, e.v});
      cmp("make",     {7'd0, o_make},     {7'd0, e.m});
      cmp("shift",    {7'd0, o_shift},    {7'd0, e.s});
      cmp("capslock", {7'd0, o_capslock}, {7'd0, e.c});
    end
  endtask

  // Drive one cycle (byte or idle) at a negedge, check after the posedge
  task automatic step(input logic v, input logic [7:0] b, input logic m);
    exp_t e;
    step_no++;
    i_byte       = b;
    i_byte_valid = v;
    e.sc = e_sc; e.v = e_v; e.m = m; e.s = e_s; e.c = e_c;
    q.push_back(e);
    @(negedge clk);
    i_byte_valid = 1'b0;
    pop_check();
  endtask

  task automatic key(input logic [7:0] b, input logic m);
    step(1'b1, b, m);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] ext_seq [10];

  initial begin
    ext_seq = '{8'hE0, 8'h12, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h12};
    i_rst        = 1'b1;
    i_byte       = 8'h00;
    i_byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    q.push_back('{sc: 8'h00, v: 1'b0, m: 1'b0, s: 1'b0, c: 1'b0});
    pop_check();
    i_rst = 1'b0;
    idle();

    // Plain make, one-cycle o_make, then break of the same key
    e_sc = 8'h1C; e_v = 1'b1;
    key(8'h1C, 1'b1);
    idle();
    key(8'hF0, 1'b0);
    e_v = 1'b0;
    key(8'h1C, 1'b0);

    // Shift held around a key press, back-to-back bytes
    e_s = 1'b1; key(8'h12, 1'b0);
    e_v = 1'b1; key(8'h1C, 1'b1);
    key(8'hF0, 1'b0);
    e_s = 1'b0; key(8'h12, 1'b0);

    // Right shift alone
    e_s = 1'b1; key(8'h59, 1'b0);
    key(8'hF0, 1'b0);
    e_s = 1'b0; key(8'h59, 1'b0);

    // Capslock toggles once per press, repeats blocked
    e_c = 1'b1; key(8'h58, 1'b0);
    key(8'h58, 1'b0);
    key(8'h58, 1'b0);
    key(8'hF0, 1'b0);
    key(8'h58, 1'b0);
    e_c = 1'b0; key(8'h58, 1'b0);
    key(8'hF0, 1'b0);
    key(8'h58, 1'b0);

    // Extended codes including fake shifts are discarded
    foreach (ext_seq[i]) key(ext_seq[i], 1'b0);

    // Ignore-list bytes and a break of a key that is not shown
    key(8'hAA, 1'b0);
    key(8'hFA, 1'b0);
    key(8'h00, 1'b0);
    key(8'hF0, 1'b0);
    key(8'h2A, 1'b0);

    // Resync: F0 E0 1C becomes an extended make, ignored
    key(8'hF0, 1'b0);
    key(8'hE0, 1'b0);
    key(8'h1C, 1'b0);

    // Just inside the timeout the break prefix is still pending
    key(8'hF0, 1'b0);
    repeat (T_CYC - 1) idle();
    e_v = 1'b0;
    key(8'h1C, 1'b0);

    // At the timeout the prefix is dropped and 1C is a make
    key(8'hF0, 1'b0);
    repeat (T_CYC) idle();
    e_v = 1'b1;
    key(8'h1C, 1'b1);

    // Typematic repeats
    key(8'hF0, 1'b0);
    e_v = 1'b0;
    key(8'h1C, 1'b0);
    e_v = 1'b1;
    key(8'h1C, 1'b1);
    key(8'h1C, REP_MAKE);
    key(8'h1C, REP_MAKE);
    idle();

    // Reset with a break pending and modifiers set
    e_s = 1'b1; key(8'h12, 1'b0);
    e_c = 1'b1; key(8'h58, 1'b0);
    key(8'hF0, 1'b0);
    i_rst = 1'b1;
    #1;
    e_sc = 8'h00; e_v = 1'b0; e_s = 1'b0; e_c = 1'b0;
    q.push_back('{sc: 8'h00, v: 1'b0, m: 1'b0, s: 1'b0, c: 1'b0});
    pop_check();
    @(negedge clk);
    i_rst = 1'b0;
    idle();
    e_sc = 8'h1C; e_v = 1'b1;
    key(8'h1C, 1'b1);
    idle();

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL queue_left observed=%0d expected=0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keystate.md
# ps2_keystate

Protocol-level key tracker between the PS/2 byte receiver and `scancode2ascii`. It consumes raw Set-2 bytes and strips the `E0`/`F0` prefixes. It tracks left/right shift and a capslock toggle, and holds the scancode of the most recently pressed key for as long as that key is down. Its `o_scancode`/`o_valid`/`o_shift`/`o_capslock` outputs drive `i_scancode`/`i_valid`/`i_shift`/`i_capslock` of `scancode2ascii` directly.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles after which a pending prefix is discarded (≈20 ms at 50 MHz).
- `CNT_W`, default 20: prefix-timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  system clock. One clock domain; asynchronous and active-high reset.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_byte`  in  8  received PS/2 data byte.
- `i_byte_valid`  in  1  one-cycle strobe; `i_byte` is valid this cycle.
- `o_scancode`  out  8  make code of the last non-modifier, non-extended key pressed.
- `o_valid`  out  1  high while the key in `o_scancode` is held.
- `o_make`  out  1  one-cycle strobe on each accepted make of a non-modifier key.
- `o_shift`  out  1  left or right shift held.
- `o_capslock`  out  1  capslock toggle state.

## Operation
- Prefix FSM states:
  - IDLE: no prefix pending.
  - EXT: `E0` seen.
  - BRK: `F0` seen.
  - EXT_BRK: `E0 F0` seen.
- Transitions on `i_byte_valid`:
  - IDLE + `E0` → EXT.
  - IDLE + `F0` → BRK.
  - EXT + `F0` → EXT_BRK.
  - `E0` in BRK or EXT_BRK → EXT. This is a protocol resync; the pending break is dropped.
  - Any other byte resolves the code and returns the FSM to IDLE.
- Bytes ignored in IDLE (no state change): `00`, `AA`, `EE`, `FA`, `FC`, `FE`, `FF`.
- Extended codes (resolved from EXT or EXT_BRK) are discarded. They do not affect `o_shift` or `o_scancode`; this covers the fake-shift sequences `E0 12` and `E0 59`.
- Shift tracking:
  - Left shift `12` and right shift `59` are tracked independently.
  - A make sets the corresponding held bit; a break clears it.
  - `o_shift` = left held OR right held.
- Capslock `58`:
  - The first make toggles `o_capslock`; a tracked held bit blocks typematic repeats.
  - A break clears the held bit.
- Modifiers (`12`, `59`, `58`) never change `o_scancode`, `o_valid` or `o_make`.
- Other make code C: `o_scancode` ← C, `o_valid` ← 1, `o_make` pulses.
- Other break code C: if C == `o_scancode`, `o_valid` ← 0. Otherwise no output change.
- Prefix timeout:
  - The counter clears on every `i_byte_valid` and counts while the FSM is not in IDLE.
  - When the count reaches TIMEOUT_CYCLES − 1, the FSM returns to IDLE and the counter clears.
  - The pending prefix is lost silently.
- Reset mid-sequence: all state clears. A byte arriving after reset is parsed from IDLE.

## Timing
- All outputs are registered.
- Reset values: `o_scancode` = 00, `o_valid` = 0, `o_make` = 0, `o_shift` = 0, `o_capslock` = 0. The FSM resets to IDLE and the counter to 0.
- Latency: a byte strobed at cycle n is reflected on the outputs at the clk edge ending cycle n; outputs are visible in cycle n+1.
- `o_make` is high for exactly one cycle.
- Back-to-back strobes on consecutive cycles must be handled; every byte is processed.
- If a timeout and `i_byte_valid` coincide in the same cycle, the byte wins and is parsed against the current (pre-timeout) state.

## Configuration
- `PS2_KEYSTATE_REPEAT_FILTER_EN`
  - Defined: a make of C while `o_valid` = 1 and `o_scancode` == C does not pulse `o_make`. Typematic repeats are suppressed.
  - Undefined: every make pulses `o_make`, including typematic repeats.
  - In both cases `o_scancode`/`o_valid` behave identically.

## Structure
- Shared package `ps2_pkg` holds:
  - the FSM state encoding;
  - code constants `PS2_EXT` = E0, `PS2_BRK` = F0, `PS2_LSHIFT` = 12, `PS2_RSHIFT` = 59, `PS2_CAPS` = 58;
  - the ignore-list codes.
- `scancode2ascii` reuses the modifier constants from the same package.
- One sub-module: `ps2_prefix_fsm`, containing the prefix FSM and timeout counter. It outputs a resolved `{strobe, ext, brk, code}`.
- The tracking registers live in the top module.

## Test plan
- `1C` → `o_scancode` = 1C, `o_valid` = 1, `o_make` = 1 for one cycle. Then `F0 1C` → `o_valid` = 0, `o_scancode` stays 1C.
- `12`, `1C`, `F0 12` → `o_shift` goes 1, then 0. `o_scancode` stays 1C, `o_valid` = 1 throughout.
- `58 58 58 F0 58 58` → `o_capslock` goes 1 after the first `58`, stays 1 through the repeats, and returns to 0 after the final `58`.
- `E0 12 E0 75 E0 F0 75 E0 F0 12` → `o_shift` = 0 throughout, `o_valid` unchanged, no `o_make`.
- `F0`, idle TIMEOUT_CYCLES cycles, then `1C` → `1C` is treated as a make: `o_valid` = 1, `o_make` pulses.
- `1C 1C 1C`: with `PS2_KEYSTATE_REPEAT_FILTER_EN` → one `o_make` pulse; without it → three pulses. Also assert `i_rst` mid-sequence after `F0` → all outputs 0 and the next `1C` is parsed as a make.
